mem_arbiter: RTL and testbench

- Shares the single byte-wide RAM port between instruction fetch (IF) and the data-memory stage (MEM).
- Serialises 1/2/4-byte accesses into per-byte RAM cycles and assembles read words little-endian.
- Returns one-cycle done pulses to the requesters, so the fetch word reaching the IF/ID register and the load/store data reaching MEM are both produced here.
- MEM has fixed priority over IF. IF fetches can be aborted by a flush on branch redirect.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter: FSM states, access
// lengths and the length-to-byte-count helper.
package mem_arbiter_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  // The reserved encoding 3 is served as a full word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// MEM stage, serialising 1/2/4-byte accesses and assembling words little-endian.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [2:0]        nb_q, nb_d;
  logic              own_if_q, own_if_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0][7:0]   wdata_q, wdata_d;
  logic [3:0][7:0]   asm_q, asm_d;
  logic [31:0]       if_hold_q, if_hold_d;
  logic [31:0]       mem_hold_q, mem_hold_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    nb_d       = nb_q;
    own_if_d   = own_if_q;
    we_d       = we_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    if_hold_d  = if_hold_q;
    mem_hold_d = mem_hold_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          own_if_d = 1'b0;
          we_d     = mem_we;
          base_d   = mem_addr;
          nb_d     = len_to_bytes(mem_len);
          wdata_d  = mem_wdata;
          asm_d    = '0;
          cyc_d    = 3'd1;
          ram_a_d  = mem_addr;
          if (mem_we) begin
            state_d    = S_WR;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end else if (if_req && !if_flush) begin
          own_if_d = 1'b1;
          we_d     = 1'b0;
          base_d   = if_addr;
          nb_d     = 3'd4;
          asm_d    = '0;
          cyc_d    = 3'd1;
          ram_a_d  = if_addr;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        if (own_if_q && if_flush) begin
          state_d = S_IDLE;
        end else begin
          // RAM data lags the address by one cycle, so byte k lands in cycle k+2.
          if (cyc_q >= 3'd2) asm_d[2'(cyc_q - 3'd2)] = ram_din;
          if (cyc_q < nb_q) ram_a_d = base_q + ADDR_W'(cyc_q);
          if (cyc_q == nb_q + 3'd1) state_d = S_DONE;
          else                      cyc_d   = cyc_q + 3'd1;
        end
      end
      S_WR: begin
        if (cyc_q < nb_q) begin
          ram_a_d    = base_q + ADDR_W'(cyc_q);
          ram_dout_d = wdata_q[cyc_q[1:0]];
          ram_wr_d   = 1'b1;
          cyc_d      = cyc_q + 3'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (own_if_q && !if_flush) if_hold_d  = asm_q;
        if (!own_if_q && !we_q)    mem_hold_d = asm_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      nb_q       <= '0;
      own_if_q   <= 1'b0;
      we_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      if_hold_q  <= '0;
      mem_hold_q <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      nb_q       <= nb_d;
      own_if_q   <= own_if_d;
      we_q       <= we_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      if_hold_q  <= if_hold_d;
      mem_hold_q <= mem_hold_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
    end
  end

  // A flush arriving in DONE still kills the fetch pulse.
  assign if_done   = (state_q == S_DONE) && own_if_q && !if_flush;
  assign mem_done  = (state_q == S_DONE) && !own_if_q;
  assign if_data   = if_done ? asm_q : if_hold_q;
  assign mem_rdata = (mem_done && !we_q) ? asm_q : mem_hold_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 1 KiB synchronous byte RAM model plus a
// cycle logger; the cycle in which a request is first presented is cycle 0.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] ra [0:31];
  logic        rw [0:31];
  logic [7:0]  rd [0:31];
  int if_at, mem_at, n_if, n_mem, n_wr;
  logic [31:0] ifd, memd;
  int flush_at = 0;
  int chg_at   = 0;
  logic [31:0] chg_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle 0: called right after a rising edge, caller then drives requests.
  task automatic start();
    @(posedge clk); #1;
  endtask

  // Runs cycles 1..n, logging RAM port activity; each requester drops its
  // request in the cycle after its done pulse.
  task automatic run(input int n);
    if_at = 0; mem_at = 0; n_if = 0; n_mem = 0; n_wr = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (if_at != 0 && c == if_at + 1) if_req = 1'b0;
      if (mem_at != 0 && c == mem_at + 1) mem_req = 1'b0;
      if_flush = (c == flush_at);
      if (c == chg_at) if_addr = chg_addr;
      @(negedge clk);
      ra[c] = ram_a; rw[c] = ram_wr; rd[c] = ram_dout;
      if (ram_wr) n_wr++;
      if (if_done) begin
        n_if++;
        if (if_at == 0) begin if_at = c; ifd = if_data; end
      end
      if (mem_done) begin
        n_mem++;
        if (mem_at == 0) begin mem_at = c; memd = mem_rdata; end
      end
    end
    if_flush = 1'b0; flush_at = 0; chg_at = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13;
    ram[10'h020] = 8'h11; ram[10'h021] = 8'h22;
    ram[10'h040] = 8'h34; ram[10'h041] = 8'h12;
    ram[10'h008] = 8'hEF; ram[10'h009] = 8'hBE; ram[10'h00A] = 8'hAD; ram[10'h00B] = 8'hDE;
    ram[10'h000] = 8'h93; ram[10'h001] = 8'h00; ram[10'h002] = 8'h10; ram[10'h003] = 8'h00;
    ram[10'h3FE] = 8'h44; ram[10'h3FF] = 8'h33;
    ram[10'h202] = 8'h5A; ram[10'h203] = 8'h5A;

    rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
    chk("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
    chk("rst_dones", {30'b0, if_done, mem_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);

    // Word fetch at 0x100
    start(); if_req = 1'b1; if_addr = 32'h100;
    run(8);
    chk("fetch_a1", ra[1], 32'h100);
    chk("fetch_a2", ra[2], 32'h101);
    chk("fetch_a3", ra[3], 32'h102);
    chk("fetch_a4", ra[4], 32'h103);
    chk("fetch_done_cyc", if_at, 6);
    chk("fetch_data", ifd, 32'h0000_0013);
    chk("fetch_no_wr", n_wr, 0);
    chk("fetch_no_mem_done", n_mem, 0);

    // Byte store
    start(); mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd0;
    mem_addr = 32'h20; mem_wdata = 32'hAABB_CCDD;
    run(4);
    chk("bst_wr1", {31'b0, rw[1]}, 32'h1);
    chk("bst_a1", ra[1], 32'h20);
    chk("bst_dout1", {24'b0, rd[1]}, 32'hDD);
    chk("bst_wr_count", n_wr, 1);
    chk("bst_done_cyc", mem_at, 2);
    chk("bst_ram20", {24'b0, ram[10'h020]}, 32'hDD);
    chk("bst_ram21", {24'b0, ram[10'h021]}, 32'h22);

    // Half load
    start(); mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h40;
    run(6);
    chk("hld_done_cyc", mem_at, 4);
    chk("hld_data", memd, 32'h0000_1234);
    chk("hld_hold", mem_rdata, 32'h0000_1234);

    // Byte load
    start(); mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h41;
    run(5);
    chk("bld_done_cyc", mem_at, 3);
    chk("bld_data", memd, 32'h0000_0012);

    // Reserved length behaves as a word
    start(); mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h8;
    run(8);
    chk("len3_done_cyc", mem_at, 6);
    chk("len3_data", memd, 32'hDEAD_BEEF);

    // Contention: MEM word load and IF fetch in the same IDLE cycle
    start();
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h8;
    if_req = 1'b1; if_addr = 32'h0;
    run(16);
    chk("cont_mem_done_cyc", mem_at, 6);
    chk("cont_mem_data", memd, 32'hDEAD_BEEF);
    chk("cont_mem_a1", ra[1], 32'h8);
    chk("cont_if_a8", ra[8], 32'h0);
    chk("cont_if_done_cyc", if_at, 13);
    chk("cont_if_data", ifd, 32'h0010_0093);

    // Flush in cycle 3; a new fetch presented in cycle 4 must be granted there
    start(); if_req = 1'b1; if_addr = 32'h100;
    flush_at = 3; chg_at = 4; chg_addr = 32'h0;
    run(12);
    chk("flush_a3", ra[3], 32'h102);
    chk("flush_refetch_a5", ra[5], 32'h0);
    chk("flush_done_cyc", if_at, 10);
    chk("flush_done_count", n_if, 1);
    chk("flush_data", ifd, 32'h0010_0093);
    chk("flush_no_wr", n_wr, 0);

    // Async reset in the middle of a word store
    start(); mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
    mem_addr = 32'h200; mem_wdata = 32'h1122_3344;
    repeat (3) begin @(posedge clk); #1; end
    chk("wrst_pre_wr", {31'b0, ram_wr}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("wrst_ram_wr", {31'b0, ram_wr}, 32'h0);
    chk("wrst_ram_a", ram_a, 32'h0);
    chk("wrst_ram_dout", {24'b0, ram_dout}, 32'h0);
    chk("wrst_if_data", if_data, 32'h0);
    chk("wrst_mem_done", {31'b0, mem_done}, 32'h0);
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run(6);
    chk("wrst_no_done", n_mem, 0);
    chk("wrst_no_wr", n_wr, 0);
    chk("wrst_ram200", {24'b0, ram[10'h200]}, 32'h44);
    chk("wrst_ram201", {24'b0, ram[10'h201]}, 32'h33);
    chk("wrst_ram202", {24'b0, ram[10'h202]}, 32'h5A);

    // Address wrap
    start(); mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'hFFFF_FFFE;
    run(8);
    chk("wrap_a1", ra[1], 32'hFFFF_FFFE);
    chk("wrap_a2", ra[2], 32'hFFFF_FFFF);
    chk("wrap_a3", ra[3], 32'h0000_0000);
    chk("wrap_a4", ra[4], 32'h0000_0001);
    chk("wrap_done_cyc", mem_at, 6);
    chk("wrap_data", memd, 32'h0093_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
